// File: rtl/data_mem_unit.sv
// Data-side RAM with combinational load path and a small MMIO window
// (cycle counter, debug register, sticky misaligned-access status).
module data_mem_unit #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_WR_out,
  input  logic [2:0]  MEM_type,
  input  logic        MEM_rd_en,
  input  logic        MEM_wr_en,
  output logic [31:0] MEM_data,
  output logic [31:0] DBG_out,
  output logic        MISALIGN_fault,
  output logic [31:0] FAULT_addr
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  logic [31:0] mem_q [DEPTH];

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] dbg_q, dbg_d;
  logic        flag_q, flag_d;
  logic [31:0] faddr_q, faddr_d;

  logic          is_b, is_h, is_w, sz_ok;
  logic          aligned, in_ram, in_mmio;
  logic          acc, ok, fault;
  logic          mw, sel_cyc, sel_dbg, sel_st;
  logic          clr, ram_we;
  logic [AW-1:0] widx;
  logic [31:0]   ram_word, shifted, ram_rd;
  logic [31:0]   wdat;
  logic [3:0]    be;
  logic [31:0]   rdata;

  assign is_b  = (MEM_type == 3'b000) || (MEM_type == 3'b100);
  assign is_h  = (MEM_type == 3'b001) || (MEM_type == 3'b101);
  assign is_w  = (MEM_type == 3'b010);
  assign sz_ok = is_b | is_h | is_w;

  assign aligned = is_b
                 | (is_h & ~MEM_addr[0])
                 | (is_w & (MEM_addr[1:0] == 2'b00));

  assign in_ram  = MEM_addr < RAM_BYTES;
  assign in_mmio = MEM_addr[31:12] == MMIO_BASE[31:12];

  // Sub-word MMIO is silently dropped, so only RAM and MMIO words fault.
  assign acc   = MEM_rd_en | MEM_wr_en;
  assign ok    = acc & aligned;
  assign fault = acc & sz_ok & ~aligned
               & (in_ram | (in_mmio & is_w));

  assign mw      = ok & in_mmio & is_w;
  assign sel_cyc = mw & (MEM_addr[11:2] == 10'd0);
  assign sel_dbg = mw & (MEM_addr[11:2] == 10'd1);
  assign sel_st  = mw & (MEM_addr[11:2] == 10'd2);

  assign widx     = MEM_addr[AW+1:2];
  assign ram_word = mem_q[widx];
  assign shifted  = ram_word >> {MEM_addr[1:0], 3'b000};

  always_comb begin
    ram_rd = shifted;
    wdat   = MEM_WR_out;
    be     = 4'hF;
    if (is_b) begin
      ram_rd = {24'd0, shifted[7:0]};
      wdat   = {4{MEM_WR_out[7:0]}};
      be     = 4'b0001 << MEM_addr[1:0];
    end else if (is_h) begin
      ram_rd = {16'd0, shifted[15:0]};
      wdat   = {2{MEM_WR_out[15:0]}};
      be     = 4'b0011 << MEM_addr[1:0];
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (MEM_rd_en && ok) begin
      unique case (1'b1)
        in_ram:  rdata = ram_rd;
        sel_cyc: rdata = cycle_q;
        sel_dbg: rdata = dbg_q;
        sel_st:  rdata = {31'd0, flag_q};
        default: rdata = 32'd0;
      endcase
    end
  end

  assign ram_we = MEM_wr_en & ok & in_ram & ~Reset;

  always_ff @(posedge CLK) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  assign clr = MEM_wr_en & sel_st & MEM_WR_out[0];

  // A fault on the clearing edge re-arms the flag with the new address.
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    dbg_d   = dbg_q;
    flag_d  = flag_q;
    faddr_d = faddr_q;
    if (MEM_wr_en && sel_dbg) dbg_d = MEM_WR_out;
    if (clr) flag_d = 1'b0;
    if (fault) begin
      flag_d = 1'b1;
      if (!flag_q || clr) faddr_d = MEM_addr;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      cycle_q <= 32'd0;
      dbg_q   <= 32'd0;
      flag_q  <= 1'b0;
      faddr_q <= 32'd0;
    end else begin
      cycle_q <= cycle_d;
      dbg_q   <= dbg_d;
      flag_q  <= flag_d;
      faddr_q <= faddr_d;
    end
  end

  assign MEM_data       = rdata;
  assign DBG_out        = dbg_q;
  assign MISALIGN_fault = flag_q;
  assign FAULT_addr     = faddr_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: byte-level reference model,
// directed plan cases followed by randomized traffic.
module tb_data_mem_unit;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] MB    = 32'hFFFF_0000;
  localparam logic [31:0] RB    = 32'(DEPTH * 4);

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] MEM_addr = '0;
  logic [31:0] MEM_WR_out = '0;
  logic [2:0]  MEM_type = '0;
  logic        MEM_rd_en = 1'b0;
  logic        MEM_wr_en = 1'b0;
  logic [31:0] MEM_data;
  logic [31:0] DBG_out;
  logic        MISALIGN_fault;
  logic [31:0] FAULT_addr;

  data_mem_unit #(.DEPTH(DEPTH), .MMIO_BASE(MB)) dut (
    .CLK(CLK),
    .Reset(Reset),
    .MEM_addr(MEM_addr),
    .MEM_WR_out(MEM_WR_out),
    .MEM_type(MEM_type),
    .MEM_rd_en(MEM_rd_en),
    .MEM_wr_en(MEM_wr_en),
    .MEM_data(MEM_data),
    .DBG_out(DBG_out),
    .MISALIGN_fault(MISALIGN_fault),
    .FAULT_addr(FAULT_addr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [31:0] dbg;
    logic        flg;
    logic [31:0] fa;
    bit          hk;
    logic [31:0] k;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  int   opn = 0;

  logic [7:0]  m [DEPTH*4];
  logic [31:0] cyc, dbg, fa;
  logic        flg;

  task automatic chk(input string nm, input int id,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s op%0d actual=%08h required=%08h",
               nm, id, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("DATA", me.id, MEM_data, me.data);
      chk("DBG", me.id, DBG_out, me.dbg);
      chk("FLAG", me.id, {31'd0, MISALIGN_fault}, {31'd0, me.flg});
      chk("FADDR", me.id, FAULT_addr, me.fa);
      if (me.hk) chk("PLAN", me.id, MEM_data, me.k);
    end
  end

  task automatic op(input logic [31:0] a, input logic [31:0] wd,
                    input logic [2:0] t, input logic rd,
                    input logic wr, input logic rs,
                    input bit hk = 1'b0,
                    input logic [31:0] k = 32'd0);
    int          n;
    bit          ram, mmio, mis, flt, okc, clr;
    logic [31:0] rv;
    logic [11:0] off;
    exp_t        e;
    n = (t == 3'd0 || t == 3'd4) ? 1 :
        (t == 3'd1 || t == 3'd5) ? 2 :
        (t == 3'd2) ? 4 : 0;
    ram  = a < RB;
    mmio = a[31:12] == MB[31:12];
    off  = a[11:0];
    mis  = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'd0);
    flt  = (rd || wr) && n != 0 && mis && (ram || (mmio && n == 4));
    okc  = (rd || wr) && n != 0 && !mis;
    rv   = '0;
    if (rd && okc) begin
      if (ram) begin
        for (int i = 0; i < n; i++) rv[8*i +: 8] = m[int'(a) + i];
      end else if (mmio && n == 4) begin
        case (off)
          12'h000: rv = cyc;
          12'h004: rv = dbg;
          12'h008: rv = {31'd0, flg};
          default: rv = '0;
        endcase
      end
    end
    e.id = opn; e.data = rv; e.dbg = dbg; e.flg = flg;
    e.fa = fa; e.hk = hk; e.k = k;
    q.push_back(e);
    MEM_addr = a; MEM_WR_out = wd; MEM_type = t;
    MEM_rd_en = rd; MEM_wr_en = wr; Reset = rs;
    @(posedge CLK);
    if (rs) begin
      cyc = '0; dbg = '0; flg = 1'b0; fa = '0;
    end else begin
      clr = 1'b0;
      if (wr && okc && ram) begin
        for (int i = 0; i < n; i++) m[int'(a) + i] = wd[8*i +: 8];
      end
      if (wr && okc && mmio && n == 4) begin
        if (off == 12'h004) dbg = wd;
        if (off == 12'h008 && wd[0]) clr = 1'b1;
      end
      if (flt) begin
        if (!flg || clr) fa = a;
        flg = 1'b1;
      end else if (clr) begin
        flg = 1'b0;
      end
      cyc = cyc + 32'd1;
    end
    opn++;
    #1;
  endtask

  task automatic idle();
    op(32'd0, 32'd0, 3'b010, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int          r;
    logic [31:0] a;
    repeat (2) @(posedge CLK);
    #1;
    cyc = '0; dbg = '0; flg = 1'b0; fa = '0;
    for (int w = 0; w < 64; w++)
      op(32'(w * 4), 32'd0, 3'b010, 1'b0, 1'b1, 1'b0);

    op(32'h10, 32'h1122_3344, 3'b010, 0, 1, 0);
    op(32'h11, 32'h0000_00AA, 3'b000, 0, 1, 0);
    op(32'h10, 32'h0, 3'b010, 1, 0, 0, 1, 32'h1122_AA44);
    op(32'h13, 32'h0, 3'b100, 1, 0, 0, 1, 32'h0000_0011);

    op(32'h22, 32'h0000_BEEF, 3'b001, 0, 1, 0);
    op(32'h22, 32'h0, 3'b101, 1, 0, 0, 1, 32'h0000_BEEF);
    op(32'h20, 32'h0, 3'b010, 1, 0, 0, 1, 32'hBEEF_0000);

    op(32'h06, 32'h0, 3'b010, 1, 0, 0, 1, 32'h0);
    op(32'h0B, 32'h1234, 3'b001, 0, 1, 0);
    op(MB + 8, 32'h0, 3'b010, 1, 0, 0, 1, 32'h1);
    op(32'h08, 32'h0, 3'b010, 1, 0, 0, 1, 32'h0);
    op(MB + 8, 32'h1, 3'b010, 0, 1, 0);
    op(MB + 8, 32'h0, 3'b010, 1, 0, 0, 1, 32'h0);

    op(32'h05, 32'h0, 3'b001, 1, 0, 0);
    op(MB + 8, 32'h1, 3'b010, 0, 1, 0);
    op(32'h31, 32'h0, 3'b010, 1, 0, 0, 1, 32'h0);
    op(MB + 8, 32'h0, 3'b010, 1, 0, 0, 1, 32'h1);

    op(32'h0, 32'h0, 3'b010, 0, 0, 1);
    op(32'h0, 32'h0, 3'b010, 0, 0, 1);
    repeat (5) idle();
    op(MB, 32'h0, 3'b010, 1, 0, 0, 1, 32'd5);
    op(MB + 4, 32'hCAFE_F00D, 3'b010, 0, 1, 0);
    op(MB + 4, 32'h0, 3'b010, 1, 0, 0, 1, 32'hCAFE_F00D);
    op(MB + 4, 32'h55, 3'b000, 0, 1, 0);
    op(MB + 4, 32'h0, 3'b010, 1, 0, 0, 1, 32'hCAFE_F00D);
    op(MB + 4, 32'h0, 3'b000, 1, 0, 0, 1, 32'h0);

    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    cyc = 32'hFFFF_FFFF;
    op(MB, 32'h0, 3'b010, 1, 0, 0, 1, 32'hFFFF_FFFF);
    op(MB, 32'h0, 3'b010, 1, 0, 0, 1, 32'h0);

    op(MB + 4, 32'h1234_5678, 3'b010, 0, 1, 1);
    op(MB + 4, 32'h0, 3'b010, 1, 0, 0, 1, 32'h0);
    op(RB, 32'h0, 3'b010, 1, 0, 0, 1, 32'h0);
    op(RB, 32'hDEAD, 3'b010, 0, 1, 0);
    op(MB + 8, 32'h0, 3'b010, 1, 0, 0, 1, 32'h0);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, 255));
      else if (r == 7) a = MB + 32'($urandom_range(0, 15));
      else if (r == 8) a = RB + 32'($urandom_range(0, 63));
      else             a = 32'h8000_0000 | 32'($urandom_range(0, 15));
      op(a, $urandom, 3'($urandom_range(0, 7)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         ($urandom_range(0, 99) == 0));
    end
    idle();

    repeat (3) @(negedge CLK);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Data-side memory for the 3-stage RV32I core. Sits directly downstream of the CPU top level's memory port and consumes its stage-3 address, write data, size code and strobes. Returns load data combinationally in the same cycle, so the core's stage-3 load path needs no stall. Also provides a small MMIO window: cycle counter, debug output register and misaligned-access fault status.

## Interface
Parameters:
- DEPTH, 1024, RAM size in 32-bit words; must be a power of two, max 16384.
- MMIO_BASE, 32'hFFFF_0000, base of the MMIO window; 4 KB aligned.

Ports:
- CLK  input  1  rising-edge clock; the block's only clock.
- Reset  input  1  synchronous, active-high reset.
- MEM_addr  input  32  byte address from CPU stage 3; zero when no access.
- MEM_WR_out  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- MEM_type  input  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- MEM_rd_en  input  1  load strobe.
- MEM_wr_en  input  1  store strobe.
- MEM_data  output  32  load data, right-aligned, upper bits zero; the core sign-extends.
- DBG_out  output  32  current value of the debug register.
- MISALIGN_fault  output  1  sticky misaligned-access flag.
- FAULT_addr  output  32  address of the first misaligned access since the flag was last cleared.

## Operation
- Decode:
  - RAM region when MEM_addr < DEPTH*4.
  - MMIO region when MEM_addr[31:12] == MMIO_BASE[31:12].
  - Any other address is unmapped: reads return 0 and writes are ignored. Unmapped accesses do not fault.
- Size and alignment:
  - B/BU are always aligned.
  - H/HU require addr[0]==0.
  - W requires addr[1:0]==0.
  - Codes 011, 110 and 111 are treated as no access: MEM_data=0, no write, no fault.
- Misaligned access (rd_en or wr_en asserted):
  - The access is suppressed: no write, MEM_data=0.
  - MISALIGN_fault is set on the next edge.
  - FAULT_addr captures MEM_addr only if the flag was 0; later faults do not overwrite it.
- RAM read: MEM_data = word[addr[..:2]] >> (8*addr[1:0]), masked to the access size (8/16/32 bits).
- RAM write: on the clock edge, writes byte lanes selected by size and addr[1:0] with MEM_WR_out[7:0], [15:0] or [31:0]. Other lanes are unchanged.
- MMIO map (word accesses only; sub-word MMIO accesses read 0 and write nothing, no fault):
  - +0x0 CYCLE: read-only 32-bit free-running counter. Writes are ignored.
  - +0x4 DBG: read/write; drives DBG_out.
  - +0x8 STATUS: read returns {31'b0, MISALIGN_fault}. Writing with bit0=1 clears the flag (W1C); writing bit0=0 has no effect.
  - Other offsets: read 0, write ignored.
- Simultaneous MEM_rd_en and MEM_wr_en: the write is performed, and MEM_data shows the pre-write contents.
- MEM_data is 0 whenever MEM_rd_en=0.
- Reset:
  - Clears CYCLE, DBG, MISALIGN_fault and FAULT_addr to 0.
  - Reset has priority over any same-cycle write or fault.
  - RAM contents are not cleared; they are undefined until written.

## Timing
- Read: combinational. MEM_data is valid in the same cycle that MEM_addr, MEM_type and MEM_rd_en are stable.
- Write: takes effect at the rising CLK edge where MEM_wr_en=1. A load of the same address in the next cycle returns the new data.
- CYCLE:
  - Increments by 1 every edge while Reset=0 and wraps from 0xFFFFFFFF to 0.
  - A read returns the pre-increment value for that cycle.
  - Value is 0 in the first cycle after reset release.
- MISALIGN_fault and FAULT_addr update one edge after the faulting access.
- W1C clear and a new fault on the same edge: the fault wins. The flag stays 1 and FAULT_addr captures the new address.
- DBG_out updates one edge after the store.
- Output reset values: MEM_data=0 (no rd_en), DBG_out=0, MISALIGN_fault=0, FAULT_addr=0.

## Test plan
- Byte lanes:
  - Stimulus: SW 0x11223344 @0x10; SB 0xAA @0x11; LW @0x10; LBU @0x13.
  - Response: LW returns 0x1122AA44; LBU returns 0x00000011.
- Halfword:
  - Stimulus: SH 0xBEEF @0x22; LHU @0x22; LW @0x20 (word previously 0).
  - Response: LHU returns 0x0000BEEF; LW returns 0xBEEF0000.
- Misaligned:
  - Stimulus: LW @0x06, then SH @0x0B with data 0x1234; then STATUS write 0x1.
  - Response: MEM_data=0; MISALIGN_fault=1 next cycle; FAULT_addr=0x06, not 0x0B; memory at 0x08 unchanged; flag cleared after the STATUS write.
- Clear/fault race:
  - Stimulus: same cycle as a STATUS W1C write, a misaligned access to 0x31 (by a second bench driver modelling back-to-back ops) is asserted.
  - Response: flag remains 1; FAULT_addr=0x31.
- MMIO:
  - Stimulus: Reset for 2 cycles, release, read CYCLE after 5 edges; SW 0xCAFEF00D @MMIO_BASE+4; SB @MMIO_BASE+4.
  - Response: CYCLE reads 5; DBG_out=0xCAFEF00D one edge after the SW; the SB leaves DBG_out unchanged.
- Wrap, reset and unmapped:
  - Stimulus: force CYCLE to 0xFFFFFFFF via reset-free run (or preload hook), step 1 edge; assert Reset in a cycle that also has a DBG write; LW @DEPTH*4.
  - Response: CYCLE=0 after the step; DBG_out=0 after the reset (write discarded); unmapped LW returns 0 with no fault.
